// File: rtl/spi_slave_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_tx_stream
// Description : SPI-slave transmitter fed from an AXI4-Stream source. SCK and
//               CS are oversampled in axis_aclk. Words are buffered in a small
//               FIFO and shifted out on MISO in the configured SPI mode.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_tx_stream #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter bit                LSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD = '1
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic                    spi_clk,
    input  logic                    spi_cs,
    output logic                    spi_miso,
    output logic                    spi_miso_oe,
    input  logic [DATA_W-1:0]       axis_rdata,
    input  logic                    axis_rvalid,
    output logic                    axis_rready,
    input  logic                    axis_rlast,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    underrun,
    output logic                    pkt_sent,
    output logic                    frame_done
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_CNT_W = $clog2(DATA_W + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    // ------------------------------------------------------------------
    // Synchronisers: bit 0 metastable stage, bit 1 synced, bit 2 previous
    // ------------------------------------------------------------------
    logic [2:0] sck_pipe_q;
    logic [2:0] cs_pipe_q;

    // Two-flop synchronisers plus one edge-detect stage for SCK and CS
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            sck_pipe_q <= {3{CPOL}};
            cs_pipe_q  <= 3'b111;
        end else begin
            sck_pipe_q <= {sck_pipe_q[1:0], spi_clk};
            cs_pipe_q  <= {cs_pipe_q[1:0], spi_cs};
        end
    end

    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    logic w_lead, w_trail, w_sample_edge, w_shift_edge;

    assign w_sck_rise    =  sck_pipe_q[1] & ~sck_pipe_q[2];
    assign w_sck_fall    = ~sck_pipe_q[1] &  sck_pipe_q[2];
    assign w_cs_fall     = ~cs_pipe_q[1]  &  cs_pipe_q[2];
    assign w_cs_rise     =  cs_pipe_q[1]  & ~cs_pipe_q[2];
    assign w_lead        = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail       = CPOL ? w_sck_rise : w_sck_fall;
    assign w_sample_edge = CPHA ? w_trail : w_lead;
    assign w_shift_edge  = CPHA ? w_lead  : w_trail;

    // ------------------------------------------------------------------
    // FIFO holding {rlast, rdata}
    // ------------------------------------------------------------------
    logic [DATA_W:0]      mem_q [DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_LVL_W-1:0]   level_q, level_d;
    logic                 rready_q;
    logic                 w_push, w_pop;
    logic [DATA_W:0]      w_head;

    assign w_push = axis_rvalid & rready_q;
    assign w_head = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge axis_aclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {axis_rlast, axis_rdata};
        end
    end

    // Occupancy: simultaneous push and pop leave the level unchanged
    always_comb begin
        level_d = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + c_LVL_ONE;
        end else if (!w_push && w_pop) begin
            level_d = level_q - c_LVL_ONE;
        end
    end

    // Pointers, level and registered ready (ready = not full next cycle)
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rready_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            level_q  <= level_d;
            rready_q <= (level_d != c_LVL_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and shifter
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [c_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                cur_last_q, cur_last_d;
    logic                skip_q, skip_d;
    logic                underrun_q, pkt_sent_q, frame_done_q;

    logic                w_edge_ok, w_frame_start, w_sample, w_shift, w_skip_clear;
    logic                w_word_end, w_fetch, w_underrun, w_pkt_end;
    logic [DATA_W-1:0]   w_load_word, w_shifted;
    logic                w_load_last, w_miso_bit;

    assign w_load_word = w_pop ? w_head[DATA_W-1:0] : IDLE_WORD;
    assign w_load_last = w_pop & w_head[DATA_W];

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_miso_bit = shreg_q[0];
            assign w_shifted  = {1'b0, shreg_q[DATA_W-1:1]};
        end else begin : g_msb_first
            assign w_miso_bit = shreg_q[DATA_W-1];
            assign w_shifted  = {shreg_q[DATA_W-2:0], 1'b0};
        end
    endgenerate

    assign spi_miso = w_miso_bit;

    // State register
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: CS rise always wins, a fully sampled rlast word starts draining
    always_comb begin
        state_d = state_q;
        if (w_cs_rise) begin
            state_d = c_ST_IDLE;
        end else begin
            case (state_q)
                c_ST_IDLE:   if (w_cs_fall) state_d = c_ST_ACTIVE;
                c_ST_ACTIVE: if (w_pkt_end) state_d = c_ST_DRAIN;
                default:     state_d = state_q;
            endcase
        end
    end

    // FSM outputs: output enable and per-cycle control strobes
    always_comb begin
        spi_miso_oe   = (state_q != c_ST_IDLE);
        w_edge_ok     = (state_q != c_ST_IDLE) && !w_cs_rise;
        w_frame_start = (state_q == c_ST_IDLE) && w_cs_fall;
        w_sample      = w_edge_ok && w_sample_edge;
        w_shift       = w_edge_ok && w_shift_edge && !skip_q;
        w_skip_clear  = w_edge_ok && w_shift_edge && skip_q;
        w_word_end    = w_shift && (bit_cnt_q == c_CNT_FULL);
        w_fetch       = w_frame_start || (w_word_end && (state_q == c_ST_ACTIVE));
        w_pop         = w_fetch && (level_q != '0);
        w_underrun    = w_fetch && (level_q == '0);
        w_pkt_end     = w_sample && (state_q == c_ST_ACTIVE) &&
                        (bit_cnt_q == c_CNT_LAST) && cur_last_q;
    end

    // Shifter datapath: load at frame start or word boundary, else count/shift
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        cur_last_d = cur_last_q;
        skip_d     = skip_q;
        if (w_cs_rise) begin
            bit_cnt_d = '0;
            skip_d    = 1'b0;
        end else if (w_frame_start) begin
            shreg_d    = w_load_word;
            cur_last_d = w_load_last;
            bit_cnt_d  = '0;
            skip_d     = CPHA;
        end else if (w_sample) begin
            bit_cnt_d = bit_cnt_q + c_CNT_ONE;
        end else if (w_skip_clear) begin
            skip_d = 1'b0;
        end else if (w_word_end) begin
            shreg_d    = w_load_word;
            cur_last_d = w_load_last;
            bit_cnt_d  = '0;
        end else if (w_shift) begin
            shreg_d = w_shifted;
        end
    end

    // Shifter registers and single-cycle status pulses
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            cur_last_q   <= 1'b0;
            skip_q       <= 1'b0;
            underrun_q   <= 1'b0;
            pkt_sent_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_last_q   <= cur_last_d;
            skip_q       <= skip_d;
            underrun_q   <= w_underrun;
            pkt_sent_q   <= w_pkt_end;
            frame_done_q <= w_cs_rise;
        end
    end

    assign axis_rready = rready_q;
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;
    assign pkt_sent    = pkt_sent_q;
    assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_tx_stream
// Description : Self-checking bench for spi_slave_tx_stream. Two instances:
//               mode 0 MSB-first and mode 3 LSB-first. A word-level model
//               predicts MISO words, pulse counts and FIFO level per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_tx_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sck  [2];
    logic          cs   [2];
    logic          miso [2];
    logic          oe   [2];
    logic [DW-1:0] dat  [2];
    logic          vld  [2];
    logic          rdy  [2];
    logic          lst  [2];
    logic [4:0]    lvl  [2];
    logic          und  [2];
    logic          pkt  [2];
    logic          fdn  [2];

    spi_slave_tx_stream #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut0 (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .spi_clk(sck[0]), .spi_cs(cs[0]), .spi_miso(miso[0]), .spi_miso_oe(oe[0]),
        .axis_rdata(dat[0]), .axis_rvalid(vld[0]), .axis_rready(rdy[0]), .axis_rlast(lst[0]),
        .fifo_level(lvl[0]), .underrun(und[0]), .pkt_sent(pkt[0]), .frame_done(fdn[0])
    );

    spi_slave_tx_stream #(.DATA_W(DW), .DEPTH(DEPTH), .CPOL(1'b1), .CPHA(1'b1),
                          .LSB_FIRST(1'b1)) u_dut1 (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .spi_clk(sck[1]), .spi_cs(cs[1]), .spi_miso(miso[1]), .spi_miso_oe(oe[1]),
        .axis_rdata(dat[1]), .axis_rvalid(vld[1]), .axis_rready(rdy[1]), .axis_rlast(lst[1]),
        .fifo_level(lvl[1]), .underrun(und[1]), .pkt_sent(pkt[1]), .frame_done(fdn[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    int   und_cnt  [2];
    int   pkt_cnt  [2];
    int   fd_cnt   [2];
    logic prev_und [2];
    logic prev_pkt [2];
    logic prev_fd  [2];
    logic [2:0] csh [2];
    int   since_rst;

    logic [8:0]    mq   [$];   // model FIFO contents {last, data}
    logic [DW-1:0] rx_w [$];   // words captured by the master in the last frame

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // CS history as seen at each clock edge; oe must follow CS three edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csh[0]    <= 3'b111;
            csh[1]    <= 3'b111;
            since_rst <= 0;
        end else begin
            csh[0]    <= {csh[0][1:0], cs[0]};
            csh[1]    <= {csh[1][1:0], cs[1]};
            since_rst <= since_rst + 1;
        end
    end

    // Every-cycle checks and pulse counting
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (since_rst >= 1) chk("rready_vs_level", int'(rdy[k]), int'(lvl[k] != 5'd16));
                chk("oe_vs_cs", int'(oe[k]), int'(!csh[k][2]));
                chk("level_bound", int'(lvl[k] <= 5'd16), 1);
                chk("pulse_width", int'((und[k] & prev_und[k]) | (pkt[k] & prev_pkt[k]) |
                                        (fdn[k] & prev_fd[k])), 0);
                und_cnt[k]  <= und_cnt[k] + int'(und[k]);
                pkt_cnt[k]  <= pkt_cnt[k] + int'(pkt[k]);
                fd_cnt[k]   <= fd_cnt[k] + int'(fdn[k]);
                prev_und[k] <= und[k];
                prev_pkt[k] <= pkt[k];
                prev_fd[k]  <= fdn[k];
            end
        end
    end

    // Push one word on stream k, waiting a bounded time for ready
    task automatic push(input int k, input logic [7:0] d, input logic l);
        bit ok;
        ok     = 1'b0;
        vld[k] = 1'b1;
        dat[k] = d;
        lst[k] = l;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (rdy[k]) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) mq.push_back({l, d});
        @(negedge clk);
        vld[k] = 1'b0;
        chk("push_accepted", int'(ok), 1);
    endtask

    // Run one CS frame of nbits SCK cycles on instance k and check against the model
    task automatic frame(input int k, input int nbits);
        bit            md;      // instance 1 is CPOL=1, CPHA=1, LSB first
        int            nw, und_e, pkt_e, und0, pkt0, fd0;
        bit            drain;
        logic [DW-1:0] exp_w [$];
        logic [DW-1:0] word;
        logic [8:0]    e;
        logic          b;
        md    = (k == 1);
        nw    = (nbits + DW - 1) / DW;
        und_e = 0;
        pkt_e = 0;
        drain = 1'b0;
        b     = 1'b0;
        und0  = und_cnt[k];
        pkt0  = pkt_cnt[k];
        fd0   = fd_cnt[k];
        // Every started word consumes one FIFO entry (or underruns) until a
        // fully sent rlast word; after that the frame carries idle fill only.
        for (int w = 0; w < nw; w++) begin
            if (drain) begin
                exp_w.push_back(8'hFF);
            end else if (mq.size() == 0) begin
                exp_w.push_back(8'hFF);
                und_e++;
            end else begin
                e = mq.pop_front();
                exp_w.push_back(e[7:0]);
                if (e[8] && (w + 1) * DW <= nbits) begin
                    pkt_e++;
                    drain = 1'b1;
                end
            end
        end
        rx_w.delete();
        word  = '0;
        cs[k] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (!md) b = miso[k];
            sck[k] = !md;
            repeat (4) @(negedge clk);
            if (md) b = miso[k];
            sck[k] = md;
            if (!md && i == nbits - 1) cs[k] = 1'b1;
            if (md) word[i % DW] = b;
            else    word[DW - 1 - (i % DW)] = b;
            if (i % DW == DW - 1) begin
                rx_w.push_back(word);
                word = '0;
            end
            repeat (4) @(negedge clk);
        end
        cs[k] = 1'b1;
        repeat (8) @(negedge clk);
        for (int w = 0; w < rx_w.size(); w++) chk("miso_word", int'(rx_w[w]), int'(exp_w[w]));
        chk("underrun_count", und_cnt[k] - und0, und_e);
        chk("pkt_sent_count", pkt_cnt[k] - pkt0, pkt_e);
        chk("frame_done_count", fd_cnt[k] - fd0, 1);
        chk("fifo_level", int'(lvl[k]), mq.size());
    endtask

    task automatic random_frames(input int k, input int iters);
        int np, nb;
        for (int it = 0; it < iters; it++) begin
            np = $urandom_range(0, 4);
            for (int p = 0; p < np; p++) begin
                if (mq.size() < DEPTH) push(k, 8'($urandom), ($urandom_range(0, 2) == 0));
            end
            if ($urandom_range(0, 1) == 1) nb = DW * $urandom_range(1, 3);
            else                          nb = $urandom_range(1, 30);
            frame(k, nb);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            sck[k] = (k == 1);
            cs[k]  = 1'b1;
            dat[k] = '0;
            vld[k] = 1'b0;
            lst[k] = 1'b0;
        end

        // Reset values while held, and ready one cycle after release
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_miso", int'(miso[k]), 0);
            chk("rst_oe", int'(oe[k]), 0);
            chk("rst_rready", int'(rdy[k]), 0);
            chk("rst_level", int'(lvl[k]), 0);
            chk("rst_pulses", int'({und[k], pkt[k], fdn[k]}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_rready", int'(rdy[k]), 1);
            chk("post_rst_level", int'(lvl[k]), 0);
            chk("post_rst_oe", int'(oe[k]), 0);
        end

        // Mode 0: two-word packet
        push(0, 8'hA5, 1'b0);
        push(0, 8'h3C, 1'b1);
        chk("t2_level_before", int'(lvl[0]), 2);
        frame(0, 16);
        chk("t2_word0", int'(rx_w[0]), 8'hA5);
        chk("t2_word1", int'(rx_w[1]), 8'h3C);
        chk("t2_level_after", int'(lvl[0]), 0);

        // Empty FIFO: idle fill with one underrun
        frame(0, 8);
        chk("t4_word", int'(rx_w[0]), 8'hFF);
        chk("t4_level", int'(lvl[0]), 0);

        // Packet end drains the rest of the frame
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b1);
        frame(0, 24);
        chk("t5_word0", int'(rx_w[0]), 8'h11);
        chk("t5_word1", int'(rx_w[1]), 8'hFF);
        chk("t5_word2", int'(rx_w[2]), 8'hFF);
        frame(0, 8);
        chk("t5_next_frame", int'(rx_w[0]), 8'h22);

        // Aborted frame discards the partial word
        push(0, 8'hA5, 1'b0);
        push(0, 8'h5A, 1'b0);
        frame(0, 3);
        chk("t6_level_after_abort", int'(lvl[0]), 1);
        frame(0, 8);
        chk("t6_next_word", int'(rx_w[0]), 8'h5A);

        // Full FIFO deasserts ready until a pop
        for (int i = 0; i < DEPTH; i++) push(0, 8'(i), 1'b0);
        chk("t6_level_full", int'(lvl[0]), 16);
        chk("t6_rready_full", int'(rdy[0]), 0);
        vld[0] = 1'b1;
        dat[0] = 8'hEE;
        repeat (5) @(negedge clk);
        chk("t6_no_push_when_full", int'(lvl[0]), 16);
        vld[0] = 1'b0;
        frame(0, 8);
        chk("t6_first_fill_word", int'(rx_w[0]), 8'h00);
        chk("t6_rready_after_pop", int'(rdy[0]), 1);

        random_frames(0, 14);

        // Mode 3, LSB first
        mq.delete();
        push(1, 8'hA5, 1'b0);
        push(1, 8'h3C, 1'b1);
        frame(1, 16);
        chk("t3_word0", int'(rx_w[0]), 8'hA5);
        chk("t3_word1", int'(rx_w[1]), 8'h3C);
        push(1, 8'h01, 1'b0);
        frame(1, 8);
        chk("t3_lsb_word", int'(rx_w[0]), 8'h01);

        random_frames(1, 14);

        // Reset in the middle of a frame flushes everything at once
        if (mq.size() < DEPTH) push(1, 8'h77, 1'b0);
        cs[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_oe_before", int'(oe[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", int'(lvl[1]), 0);
        chk("midrst_oe", int'(oe[1]), 0);
        chk("midrst_rready", int'(rdy[1]), 0);
        chk("midrst_miso", int'(miso[1]), 0);
        cs[1] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        repeat (2) @(negedge clk);
        chk("midrst_release_rready", int'(rdy[1]), 1);
        frame(1, 8);
        chk("midrst_empty_fill", int'(rx_w[0]), 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
